// File: rtl/inst_encode_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: class codes, RV32I opcodes,
// loader FSM states and instruction-format packing helpers.
package inst_encode_loader_pkg;

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_IALU   = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_LUI    = 4'd5;
    localparam logic [3:0] CLS_AUIPC  = 4'd6;
    localparam logic [3:0] CLS_JAL    = 4'd7;
    localparam logic [3:0] CLS_JALR   = 4'd8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FN7_ALT    = 7'b0100000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic        illegal;
        logic [31:0] word;
    } enc_result_t;

    // R layout: fn7[31:25] rs2[24:20] rs1[19:15] fn3[14:12] rd[11:7] opcode[6:0].
    // S and B formats reuse it with immediate pieces in the fn7/rd slots.
    function automatic logic [31:0] r_type(input logic [6:0] fn7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] fn3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {fn7, rs2, rs1, fn3, rd, opc};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm12, input logic [4:0] rs1,
                                           input logic [2:0] fn3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm12, rs1, fn3, rd, opc};
    endfunction

endpackage

// File: rtl/inst_encode_loader_fifo.sv
// Synchronous word FIFO with combinational head output; push and pop may coincide.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    // Storage has no reset: pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/inst_encode_loader.sv
// Encodes decoded RV32I field sets into machine words and streams them into
// instruction RAM at consecutive word addresses through a small FIFO.
module inst_encode_loader
    import inst_encode_loader_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cls,
    input  logic [2:0]    in_fn3,
    input  logic          in_alt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    input  logic          mem_gnt,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          done,
    output logic          err,
    output logic [AW-2:0] words
);

    function automatic enc_result_t encode(input logic [3:0] cls, input logic [2:0] fn3,
                                           input logic alt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        enc_result_t r;
        r.illegal = 1'b0;
        r.word    = 32'h0;
        case (cls)
            CLS_R: begin
                r.word    = r_type(alt ? FN7_ALT : 7'h00, rs2, rs1, fn3, rd, OPC_OP);
                r.illegal = alt && (fn3 != 3'b000) && (fn3 != 3'b101);
            end
            CLS_IALU: begin
                // Shift-immediates carry the shamt in imm[4:0] and the arithmetic flag in bit 30.
                if (fn3 == 3'b001 || fn3 == 3'b101) begin
                    r.word = i_type({1'b0, alt, 5'b0, imm[4:0]}, rs1, fn3, rd, OPC_OPIMM);
                end else begin
                    r.word = i_type(imm[11:0], rs1, fn3, rd, OPC_OPIMM);
                end
                r.illegal = alt && (fn3 != 3'b101);
            end
            CLS_LOAD: begin
                r.word    = i_type(imm[11:0], rs1, fn3, rd, OPC_LOAD);
                r.illegal = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
            end
            CLS_STORE: begin
                r.word    = r_type(imm[11:5], rs2, rs1, fn3, imm[4:0], OPC_STORE);
                r.illegal = (fn3 > 3'b010);
            end
            CLS_BRANCH: begin
                r.word    = r_type({imm[12], imm[10:5]}, rs2, rs1, fn3,
                                   {imm[4:1], imm[11]}, OPC_BRANCH);
                r.illegal = (fn3 == 3'b010) || (fn3 == 3'b011) || imm[0];
            end
            CLS_LUI:   r.word = {imm[31:12], rd, OPC_LUI};
            CLS_AUIPC: r.word = {imm[31:12], rd, OPC_AUIPC};
            CLS_JAL: begin
                r.word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                r.illegal = imm[0];
            end
            CLS_JALR: begin
                r.word    = i_type(imm[11:0], rs1, fn3, rd, OPC_JALR);
                r.illegal = (fn3 != 3'b000);
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [AW-1:0]        addr_reg;
    logic [AW-2:0]        words_reg;
    logic                 err_reg;
    enc_result_t          enc;
    logic                 accept;
    logic                 push;
    logic                 wr_fire;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] unused_fifo_count;
    logic [1:0]           unused_base_lsbs;

    always_comb begin
        enc = encode(in_cls, in_fn3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
    end

    assign in_ready = (state_reg == S_RUN) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !enc.illegal;
    assign wr_fire  = !fifo_empty && mem_gnt;

    inst_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (enc.word),
        .pop   (wr_fire),
        .dout  (mem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)      state_next = S_RUN;
            S_RUN:   if (finish)     state_next = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_next = S_DONE;
            S_DONE:                  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // The FIFO is always empty in IDLE, so start never collides with a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            words_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (wr_fire) begin
                addr_reg  <= addr_reg + AW'(4);
                words_reg <= words_reg + (AW-1)'(1);
            end
            if (accept && enc.illegal) begin
                err_reg <= 1'b1;
            end
            if (state_reg == S_IDLE && start) begin
                addr_reg  <= {base_addr[AW-1:2], 2'b00};
                words_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    assign unused_base_lsbs = base_addr[1:0];
    assign mem_we   = wr_fire ? 4'b1111 : 4'b0000;
    assign mem_addr = addr_reg;
    assign done     = (state_reg == S_DONE);
    assign err      = err_reg;
    assign words    = words_reg;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader: expected RAM writes are queued when field
// sets are driven and checked by a monitor as the write port fires.
module tb_inst_encode_loader;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_cls;
    logic [2:0]    in_fn3;
    logic          in_alt;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          mem_gnt;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          done;
    logic          err;
    logic [AW-2:0] words;

    always #5 clk = ~clk;

    inst_encode_loader #(.AW(AW), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .finish    (finish),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cls    (in_cls),
        .in_fn3    (in_fn3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .mem_gnt   (mem_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err),
        .words     (words)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] exp_addr;
    int            n_vec  = 0;
    int            n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] data);
        sb.push_back('{exp_addr, data});
        exp_addr = exp_addr + AW'(4);
    endtask

    task automatic send(input logic [3:0] cls, input logic [2:0] fn3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n = 0;
        in_cls = cls; in_fn3 = fn3; in_alt = alt;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic start_session(input logic [AW-1:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = base & ~AW'(3);
        chk("start_addr", mem_addr, exp_addr);
        chk("start_words", words, 0);
        chk("start_err", err, 0);
        chk("start_in_ready", in_ready, 1);
    endtask

    task automatic finish_session(input int nwords);
        int n = 0;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done, 1);
        chk("words_at_done", words, nwords);
        chk("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    // Write-port monitor: every write must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_we !== 4'h0) begin
                if (sb.size() == 0) begin
                    chk("spurious_write_we", mem_we, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_we", mem_we, 4'hF);
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                    $display("write @%h data %h (expected @%h %h)", mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; finish = 1'b0; in_valid = 1'b0;
        in_cls = '0; in_fn3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; mem_gnt = 1'b0; exp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words, 0);
        chk("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Immediate issue: addi x1,x0,5 ; add x3,x1,x2
        mem_gnt = 1'b1;
        start_session(12'h100);
        expect_word(32'h0050_0093); send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word(32'h0020_81B3); send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        finish_session(2);

        // finish and in_valid in IDLE are ignored
        in_valid = 1'b1; finish = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ignore_done", done, 0);
        chk("idle_ignore_ready", in_ready, 0);
        in_valid = 1'b0; finish = 1'b0;
        @(posedge clk); #1;

        // Alt and shift forms: sub, srai, lui
        start_session(12'h200);
        expect_word(32'h4020_81B3); send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word(32'h4033_5293); send(4'd1, 3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3);
        expect_word(32'h1234_50B7); send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
        finish_session(3);

        // Store, branch, jump
        start_session(12'h300);
        expect_word(32'h0020_A423); send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word(32'h0020_8463); send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word(32'h0100_00EF); send(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16);
        finish_session(3);

        // Backpressure: six addi xk,x0,k with the write port withheld
        mem_gnt = 1'b0;
        start_session(12'h400);
        for (int k = 1; k <= 4; k++) begin
            expect_word((32'(k) << 20) | (32'(k) << 7) | 32'h13);
            send(4'd1, 3'b000, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k));
        end
        chk("bp_full_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_in_ready", in_ready, 0);
        chk("bp_hold_words", words, 0);
        mem_gnt = 1'b1;
        for (int k = 5; k <= 6; k++) begin
            expect_word((32'(k) << 20) | (32'(k) << 7) | 32'h13);
            send(4'd1, 3'b000, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k));
        end
        finish_session(6);

        // Illegal input and address wrap; base low bits ignored
        start_session(12'hFFE);
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
        chk("illegal_err", err, 1);
        expect_word(32'h0010_0393); send(4'd1, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd1);
        expect_word(32'h0010_0413); send(4'd1, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd1);
        finish_session(2);
        chk("wrap_err_sticky", err, 1);
        chk("wrap_next_addr", mem_addr, 12'h004);

        // New start clears err; more illegal forms are dropped
        start_session(12'h000);
        send(4'd9, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        chk("illegal_cls_err", err, 1);
        send(4'd0, 3'b001, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0);
        send(4'd2, 3'b111, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0);
        finish_session(0);

        // Reset mid-session with three words buffered: nothing may be written
        mem_gnt = 1'b0;
        start_session(12'h500);
        for (int k = 1; k <= 3; k++) send(4'd1, 3'b000, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k));
        chk("pre_rst_in_ready", in_ready, 1);
        mem_gnt = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_mem_we", mem_we, 0);
        chk("post_rst_words", words, 0);
        chk("post_rst_idle", in_ready, 0);
        chk("post_rst_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
